// File: rtl/decode_stage.sv
// RV32I decode stage: IF/ID pipeline register and combinational decode of the held word.
// Drives regfile read addresses, write-back controls and the load-use stall.
module decode_stage #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter bit          HAZARD_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_valid,
    input  logic [31:0] if_pc,
    input  logic [31:0] if_instr,
    input  logic        flush,
    input  logic        ex_memread,
    input  logic [4:0]  ex_rd,
    output logic        stall,
    output logic [4:0]  addr1,
    output logic [4:0]  addr2,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [4:0]  id_rd,
    output logic        id_regwen,
    output logic [31:0] id_imm,
    output logic [2:0]  id_funct3,
    output logic        id_alt,
    output logic        id_alusrc,
    output logic        id_memread,
    output logic        id_memwrite,
    output logic        id_branch,
    output logic        id_jump,
    output logic        id_illegal
);
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic        use1;
        logic        use2;
        logic        wr;
        logic        alu;
        logic        mr;
        logic        mw;
        logic        br;
        logic        jp;
        logic        alt;
        logic        legal;
        logic [31:0] imm;
    } dec_t;

    logic [31:0] ir_q, ir_d, pc_q, pc_d;
    logic        v_q, v_d;
    dec_t        dec;
    logic        ok;

    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode = ir_q[6:0];
    assign rd     = ir_q[11:7];
    assign funct3 = ir_q[14:12];
    assign rs1    = ir_q[19:15];
    assign rs2    = ir_q[24:20];
    assign funct7 = ir_q[31:25];
    assign imm_i  = {{20{ir_q[31]}}, ir_q[31:20]};
    assign imm_s  = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
    assign imm_b  = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
    assign imm_u  = {ir_q[31:12], 12'b0};
    assign imm_j  = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};

    // Source-use flags follow the opcode alone, so an illegal OP word can still stall.
    always_comb begin
        dec       = '0;
        dec.legal = 1'b1;
        case (opcode)
            OPC_OP: begin
                dec.use1  = 1'b1;
                dec.use2  = 1'b1;
                dec.wr    = 1'b1;
                dec.alt   = ir_q[30];
                dec.legal = (funct7 == 7'h00) |
                            ((funct7 == 7'h20) & ((funct3 == 3'd0) | (funct3 == 3'd5)));
            end
            OPC_OPIMM: begin
                dec.use1 = 1'b1;
                dec.wr   = 1'b1;
                dec.alu  = 1'b1;
                dec.imm  = imm_i;
                if (funct3 == 3'd1) begin
                    dec.legal = (funct7 == 7'h00);
                end else if (funct3 == 3'd5) begin
                    dec.legal = (funct7 == 7'h00) | (funct7 == 7'h20);
                    dec.alt   = ir_q[30];
                end
            end
            OPC_LOAD: begin
                dec.use1  = 1'b1;
                dec.wr    = 1'b1;
                dec.alu   = 1'b1;
                dec.mr    = 1'b1;
                dec.imm   = imm_i;
                dec.legal = (funct3 != 3'd3) & (funct3 < 3'd6);
            end
            OPC_STORE: begin
                dec.use1  = 1'b1;
                dec.use2  = 1'b1;
                dec.alu   = 1'b1;
                dec.mw    = 1'b1;
                dec.imm   = imm_s;
                dec.legal = (funct3 <= 3'd2);
            end
            OPC_BRANCH: begin
                dec.use1  = 1'b1;
                dec.use2  = 1'b1;
                dec.br    = 1'b1;
                dec.imm   = imm_b;
                dec.legal = (funct3 != 3'd2) & (funct3 != 3'd3);
            end
            OPC_JALR: begin
                dec.use1 = 1'b1;
                dec.wr   = 1'b1;
                dec.alu  = 1'b1;
                dec.jp   = 1'b1;
                dec.imm  = imm_i;
            end
            OPC_JAL: begin
                dec.wr  = 1'b1;
                dec.alu = 1'b1;
                dec.jp  = 1'b1;
                dec.imm = imm_j;
            end
            OPC_LUI, OPC_AUIPC: begin
                dec.wr  = 1'b1;
                dec.alu = 1'b1;
                dec.imm = imm_u;
            end
            OPC_FENCE, OPC_SYSTEM: ;
            default: dec.legal = 1'b0;
        endcase
    end

    always_comb begin
        stall = HAZARD_EN & v_q & ex_memread & (ex_rd != 5'd0) & ~flush &
                ((dec.use1 & (rs1 == ex_rd)) | (dec.use2 & (rs2 == ex_rd)));
        ok          = v_q & ~stall & dec.legal;
        addr1       = (v_q & dec.use1) ? rs1 : 5'd0;
        addr2       = (v_q & dec.use2) ? rs2 : 5'd0;
        id_valid    = ok;
        id_pc       = ok ? pc_q : 32'd0;
        id_regwen   = ok & dec.wr & (rd != 5'd0);
        id_rd       = id_regwen ? rd : 5'd0;
        id_imm      = ok ? dec.imm : 32'd0;
        id_funct3   = ok ? funct3 : 3'd0;
        id_alt      = ok & dec.alt;
        id_alusrc   = ok & dec.alu;
        id_memread  = ok & dec.mr;
        id_memwrite = ok & dec.mw;
        id_branch   = ok & dec.br;
        id_jump     = ok & dec.jp;
        id_illegal  = v_q & ~stall & ~dec.legal;
    end

    always_comb begin
        ir_d = ir_q;
        pc_d = pc_q;
        v_d  = v_q;
        if (flush) begin
            ir_d = NOP_INSTR;
            v_d  = 1'b0;
        end else if (!stall) begin
            ir_d = if_instr;
            pc_d = if_pc;
            v_d  = if_valid;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ir_q <= NOP_INSTR;
            pc_q <= 32'd0;
            v_q  <= 1'b0;
        end else begin
            ir_q <= ir_d;
            pc_q <= pc_d;
            v_q  <= v_d;
        end
    end
endmodule

// File: tb/tb_decode_stage.sv
// Random + directed bench for decode_stage: reference model feeds a scoreboard queue,
// a negedge monitor pops and compares the full output vector every cycle.
module tb_decode_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid, flush, ex_memread;
    logic [31:0] if_pc, if_instr;
    logic [4:0]  ex_rd;
    logic        stall, id_valid, id_regwen, id_alt, id_alusrc;
    logic        id_memread, id_memwrite, id_branch, id_jump, id_illegal;
    logic [4:0]  addr1, addr2, id_rd;
    logic [31:0] id_pc, id_imm;
    logic [2:0]  id_funct3;

    decode_stage dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
        .flush(flush), .ex_memread(ex_memread), .ex_rd(ex_rd), .stall(stall),
        .addr1(addr1), .addr2(addr2), .id_valid(id_valid), .id_pc(id_pc), .id_rd(id_rd),
        .id_regwen(id_regwen), .id_imm(id_imm), .id_funct3(id_funct3), .id_alt(id_alt),
        .id_alusrc(id_alusrc), .id_memread(id_memread), .id_memwrite(id_memwrite),
        .id_branch(id_branch), .id_jump(id_jump), .id_illegal(id_illegal)
    );

    always #5 clk = ~clk;

    logic [91:0] act_vec;
    assign act_vec = {stall, addr1, addr2, id_valid, id_pc, id_rd, id_regwen, id_imm,
                      id_funct3, id_alt, id_alusrc, id_memread, id_memwrite,
                      id_branch, id_jump, id_illegal};

    int          checks = 0;
    int          errors = 0;
    int          cycle  = 0;
    logic [91:0] sb[$];
    logic [31:0] m_ir, m_pc;
    logic        m_v;

    // Reference: what the decode stage should present for a held word and current EX state.
    function automatic logic [91:0] model_out(input logic [31:0] ir, input logic [31:0] pc,
                                              input logic v, input logic fl, input logic exm,
                                              input logic [4:0] exrd);
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [4:0] r1, r2, rdx;
        logic u1, u2, wr, alu, mr, mw, br, jp, alt, legal, st, ok, wen;
        logic [31:0] imm;
        logic signed [11:0] i12;
        logic signed [12:0] b13;
        logic signed [20:0] j21;
        op = ir[6:0]; f3 = ir[14:12]; f7 = ir[31:25];
        r1 = ir[19:15]; r2 = ir[24:20]; rdx = ir[11:7];
        {u1, u2, wr, alu, mr, mw, br, jp, alt} = '0;
        legal = 1'b1;
        imm = 32'd0;
        i12 = ir[31:20];
        b13 = {ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
        j21 = {ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
        case (op)
            7'h33: begin
                u1 = 1; u2 = 1; wr = 1; alt = ir[30];
                legal = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
            end
            7'h13: begin
                u1 = 1; wr = 1; alu = 1; imm = 32'(i12);
                if (f3 == 1) legal = (f7 == 0);
                if (f3 == 5) begin legal = (f7 == 0 || f7 == 7'h20); alt = ir[30]; end
            end
            7'h03: begin
                u1 = 1; wr = 1; alu = 1; mr = 1; imm = 32'(i12);
                legal = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
            end
            7'h23: begin
                u1 = 1; u2 = 1; alu = 1; mw = 1;
                i12 = {ir[31:25], ir[11:7]}; imm = 32'(i12);
                legal = (f3 < 3);
            end
            7'h63: begin u1 = 1; u2 = 1; br = 1; imm = 32'(b13); legal = (f3 != 2 && f3 != 3); end
            7'h67: begin u1 = 1; wr = 1; alu = 1; jp = 1; imm = 32'(i12); end
            7'h6f: begin wr = 1; alu = 1; jp = 1; imm = 32'(j21); end
            7'h37, 7'h17: begin wr = 1; alu = 1; imm = ir & 32'hFFFF_F000; end
            7'h0f, 7'h73: ;
            default: legal = 1'b0;
        endcase
        st  = v && exm && exrd != 0 && !fl && ((u1 && r1 == exrd) || (u2 && r2 == exrd));
        ok  = v && !st && legal;
        wen = ok && wr && rdx != 0;
        return {st, (v && u1) ? r1 : 5'd0, (v && u2) ? r2 : 5'd0, ok, ok ? pc : 32'd0,
                wen ? rdx : 5'd0, wen, ok ? imm : 32'd0, ok ? f3 : 3'd0, ok && alt,
                ok && alu, ok && mr, ok && mw, ok && br, ok && jp, v && !st && !legal};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom;
        w[19:15] = 5'($urandom_range(0, 3));
        w[24:20] = 5'($urandom_range(0, 3));
        case ($urandom_range(0, 12))
            0: begin w[6:0] = 7'h33; if ($urandom_range(0, 3) != 0) w[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00; end
            1: begin w[6:0] = 7'h13; if ($urandom_range(0, 3) != 0) w[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00; end
            2:  w[6:0] = 7'h03;
            3:  w[6:0] = 7'h23;
            4:  w[6:0] = 7'h63;
            5:  w[6:0] = 7'h67;
            6:  w[6:0] = 7'h6f;
            7:  w[6:0] = 7'h37;
            8:  w[6:0] = 7'h17;
            9:  w[6:0] = 7'h0f;
            10: w[6:0] = 7'h73;
            11: w[6:0] = 7'h33;
            default: ;
        endcase
        return w;
    endfunction

    // Drive one cycle's inputs, queue the expected outputs, advance the model register.
    task automatic cyc(input logic iv, input logic [31:0] ipc, input logic [31:0] ins,
                       input logic fl, input logic exm, input logic [4:0] erd);
        logic [91:0] e;
        if_valid = iv; if_pc = ipc; if_instr = ins;
        flush = fl; ex_memread = exm; ex_rd = erd;
        e = model_out(m_ir, m_pc, m_v, fl, exm, erd);
        sb.push_back(e);
        if (fl) begin
            m_v = 1'b0; m_ir = NOP;
        end else if (!e[91]) begin
            m_ir = ins; m_pc = ipc; m_v = iv;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, a, e);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            logic [91:0] e;
            e = sb.pop_front();
            checks++;
            if (act_vec !== e) begin
                errors++;
                $display("FAIL scoreboard cycle=%0d actual=%h expected=%h", cycle, act_vec, e);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        if_valid = 0; if_pc = 0; if_instr = 0; flush = 0; ex_memread = 0; ex_rd = 0;
        m_ir = NOP; m_pc = 0; m_v = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_id_valid", 32'(id_valid), 0);
        chk("rst_stall", 32'(stall), 0);
        chk("rst_addr1", 32'(addr1), 0);
        chk("rst_addr2", 32'(addr2), 0);
        rst = 1'b1;
        cyc(0, 0, 0, 0, 0, 0); tick();
        cyc(0, 0, 0, 0, 0, 0); #1 chk("idle_id_valid", 32'(id_valid), 0); tick();

        // add x2,x2,x3
        cyc(1, 32'h100, 32'h0031_0133, 0, 0, 0); tick();
        cyc(0, 0, 0, 0, 0, 0); #1;
        chk("add_addr1", 32'(addr1), 2);
        chk("add_addr2", 32'(addr2), 3);
        chk("add_rd", 32'(id_rd), 2);
        chk("add_regwen", 32'(id_regwen), 1);
        chk("add_alusrc", 32'(id_alusrc), 0);
        chk("add_pc", id_pc, 32'h100);
        tick();

        // sb x0,-1(x2) then beq x0,x0,-4
        cyc(1, 32'h104, 32'hFE01_0FA3, 0, 0, 0); tick();
        cyc(1, 32'h108, 32'hFE00_0EE3, 0, 0, 0); #1;
        chk("sb_imm", id_imm, 32'hFFFF_FFFF);
        chk("sb_addr2", 32'(addr2), 0);
        chk("sb_memwrite", 32'(id_memwrite), 1);
        chk("sb_regwen", 32'(id_regwen), 0);
        tick();
        cyc(0, 0, 0, 0, 0, 0); #1 chk("beq_imm", id_imm, 32'hFFFF_FFFC); tick();

        // load-use on add x5,x4,x1
        cyc(1, 32'h200, 32'h0012_02B3, 0, 0, 0); tick();
        cyc(1, 32'h204, NOP, 0, 1, 5'd1); #1;
        chk("lu_stall", 32'(stall), 1);
        chk("lu_id_valid", 32'(id_valid), 0);
        tick();
        cyc(1, 32'h204, NOP, 0, 0, 0); #1;
        chk("lu_release_stall", 32'(stall), 0);
        chk("lu_release_pc", id_pc, 32'h200);
        chk("lu_release_rd", 32'(id_rd), 5);
        tick();

        // flush beats a pending load-use stall
        cyc(1, 32'h300, 32'h0012_02B3, 0, 0, 0); tick();
        cyc(1, 32'h304, NOP, 0, 1, 5'd4); #1 chk("fl_pre_stall", 32'(stall), 1); tick();
        cyc(1, 32'h304, NOP, 1, 1, 5'd4); #1 chk("fl_stall", 32'(stall), 0); tick();
        cyc(1, 32'h308, 32'h0031_0133, 0, 0, 0); #1 chk("fl_bubble", 32'(id_valid), 0); tick();
        cyc(0, 0, 0, 0, 0, 0); #1;
        chk("fl_next_valid", 32'(id_valid), 1);
        chk("fl_next_pc", id_pc, 32'h308);
        tick();

        // illegal word, then lui x0,1
        cyc(1, 32'h400, 32'hFFFF_FFFF, 0, 0, 0); tick();
        cyc(1, 32'h404, 32'h0000_1037, 0, 0, 0); #1;
        chk("ill_illegal", 32'(id_illegal), 1);
        chk("ill_regwen", 32'(id_regwen), 0);
        tick();
        cyc(0, 0, 0, 0, 0, 0); #1;
        chk("lui_x0_regwen", 32'(id_regwen), 0);
        chk("lui_x0_valid", 32'(id_valid), 1);
        tick();

        // asynchronous reset mid-operation
        cyc(1, 32'h500, 32'h0031_0133, 0, 0, 0); tick();
        rst = 1'b0; #1;
        chk("midrst_id_valid", 32'(id_valid), 0);
        chk("midrst_addr1", 32'(addr1), 0);
        chk("midrst_regwen", 32'(id_regwen), 0);
        m_ir = NOP; m_pc = 0; m_v = 0;
        tick();
        rst = 1'b1;

        for (int n = 0; n < 3000; n++) begin
            cyc($urandom_range(0, 3) != 0, $urandom, rand_instr(), $urandom_range(0, 9) == 0,
                $urandom_range(0, 2) == 0, 5'($urandom_range(0, 4)));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
